lsu_mem_ctrl: RTL and testbench
===============================

// Module: lsu_mem_ctrl
// PURPOSE
//  Load/store sequencer between the RV32I core's memory stage and the word-wide,
//  byte-enabled data memory (registered address, rd-gated registered read data).
//  Accepts one byte-addressed load/store request at a time and converts it to word
//  address, byte enables and lane-replicated write data. Sequences the 2-cycle read
//  pipeline, aligns and sign/zero-extends load data, and flags misaligned,
//  out-of-range or illegal-funct3 accesses without touching memory.
// PARAMETERS
//  ADDR_W   9   word-address width of data memory (depth = 2**ADDR_W words)
// PORTS
//  clk         in   1       clock, all state on rising edge
//  rst_n       in   1       asynchronous active-low reset
//  req_valid   in   1       request present
//  req_ready   out  1       controller can accept (high only in IDLE)
//  req_we      in   1       1 = store, 0 = load
//  req_funct3  in   3       RV32I funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU)
//  req_addr    in   32      byte address
//  req_wdata   in   32      store data (low bytes used for B/H)
//  resp_valid  out  1       response present; held until resp_ready
//  resp_ready  in   1       core accepts response
//  resp_rdata  out  32      aligned, extended load data (0 for stores and errors)
//  resp_err    out  1       access rejected; no memory side effect
//  mem_addr    out  ADDR_W  word address to data memory
//  mem_rd      out  1       read enable to data memory
//  mem_we      out  4       byte write enables to data memory
//  mem_wdata   out  32      lane-replicated write data
//  mem_rdata   in   32      data memory read data
// BEHAVIOUR
//  Reset: state IDLE; req_ready=1 after reset release; every other output 0.
//   Async assert mid-access drops mem_we/mem_rd immediately; in-flight request lost.
//  States: IDLE, ACCESS, LD_WAIT, RESP. Memory-side outputs driven from registers.
//  IDLE: on req_valid, latch request (req_ready=1 here, so handshake = req_valid).
//   Error check: funct3 not in {000,001,010,100,101}; store with funct3[2]=1;
//   H with addr[0]!=0; W with addr[1:0]!=0; addr[31:ADDR_W+2]!=0.
//   Error -> RESP with resp_err=1, rdata=0. Else -> ACCESS.
//  ACCESS (1 cycle): mem_addr=addr[ADDR_W+1:2].
//   Store: mem_we=B 0001<<off, H 0011<<off, W 1111 (off=addr[1:0]);
//    mem_wdata={4{wd[7:0]}} / {2{wd[15:0]}} / wd; -> RESP.
//   Load: mem_we=0, mem_rd=0 (memory registers address this edge); -> LD_WAIT.
//  LD_WAIT (1 cycle): mem_addr held, mem_rd=1; memory registers read data this edge.
//   Capture mem_rdata into response register one cycle later, in RESP entry logic.
//  RESP: resp_valid=1, mem_we=0, mem_rd=0.
//   Load data = mem_rdata>>(8*off); B/H sign-extend bit 7/15, BU/HU zero-extend.
//   resp_valid/rdata/err stable until resp_ready; resp_valid&&resp_ready -> IDLE.
//  Latency from accept edge to resp_valid: load 3 cycles, store 2, error 1.
//   Throughput = one request per (latency + 1) cycles min; no overlap.
//  mem_we is nonzero for exactly one cycle per store, never for loads or errors.
//  req_* ignored outside IDLE; resp_ready ignored outside RESP.
// TESTING
//  SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> mem_we=1111 @word 4, one cycle;
//   resp_rdata=0xDEADBEEF, resp_valid 3 cycles after load accept.
//  SB 0x13 data 0x000000A5, then LB 0x13 / LBU 0x13 -> mem_we=1000;
//   rdata 0xFFFFFFA5 / 0x000000A5; other bytes of word 4 unchanged.
//  SH 0x22 data 0x8001, then LH / LHU 0x22 -> mem_we=1100;
//   rdata 0xFFFF8001 / 0x00008001.
//  LW 0x11, SH 0x03, funct3=011, addr 0x800 (ADDR_W=9) -> resp_err=1 after 1 cycle;
//   mem_we stays 0000, mem_rd stays 0.
//  Hold resp_ready=0 for 5 cycles after load -> resp_valid/rdata stable, req_ready=0;
//   release -> IDLE next cycle.
//  Assert rst_n=0 during ACCESS of a store -> mem_we=0 immediately;
//   target word unchanged; outputs at reset values.

Source files
------------

// File: rtl/lsu_mem_ctrl_if.sv
// ---------------------------------------------------------------------------
// lsu_mem_ctrl_if
// Core-side request/response bus of the load/store sequencer.
//   req_valid/req_ready  : request handshake (core -> controller)
//   req_we               : 1 = store, 0 = load
//   req_funct3           : RV32I width/extension code
//   req_addr             : byte address
//   req_wdata            : store data (low bytes used for B/H)
//   resp_valid/resp_ready: response handshake (controller -> core)
//   resp_rdata           : aligned, extended load data
//   resp_err             : access rejected without memory side effect
// Modports: master = core side, slave = controller side.
// ---------------------------------------------------------------------------
interface lsu_mem_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// ---------------------------------------------------------------------------
// lsu_mem_ctrl
// Load/store sequencer between the core memory stage and a word-wide,
// byte-enabled data memory with registered address and rd-gated registered
// read data. One request at a time: IDLE -> ACCESS -> (LD_WAIT) -> RESP.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   bus (slave)     : core request/response bus
//   mem_addr_o      : word address to memory
//   mem_rd_o        : read enable to memory
//   mem_we_o        : byte write enables
//   mem_wdata_o     : lane-replicated write data
//   mem_rdata_i     : memory read data
// ---------------------------------------------------------------------------
module lsu_mem_ctrl #(
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  lsu_mem_ctrl_if.slave     bus,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_rd_o,
  output logic [3:0]        mem_we_o,
  output logic [31:0]       mem_wdata_o,
  input  logic [31:0]       mem_rdata_i
);

  typedef enum logic [1:0] {IDLE, ACCESS, LD_WAIT, RESP} state_t;

  state_t            state_q, state_d;
  logic              op_we_q, op_we_d;
  logic [2:0]        f3_q, f3_d;
  logic [1:0]        off_q, off_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [3:0]        mem_we_q, mem_we_d;
  logic              mem_rd_q, mem_rd_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              err_q, err_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              ld_cap_q, ld_cap_d;

  // Request decode: legality, byte enables, lane replication.
  logic        req_bad;
  logic [3:0]  req_be;
  logic [31:0] req_wlane;

  always_comb begin
    req_bad   = 1'b0;
    req_be    = 4'b1111;
    req_wlane = bus.req_wdata;
    case (bus.req_funct3)
      3'b000, 3'b100: begin
        req_be    = 4'b0001 << bus.req_addr[1:0];
        req_wlane = {4{bus.req_wdata[7:0]}};
      end
      3'b001, 3'b101: begin
        req_be    = 4'b0011 << bus.req_addr[1:0];
        req_wlane = {2{bus.req_wdata[15:0]}};
        req_bad   = bus.req_addr[0];
      end
      3'b010:  req_bad = (bus.req_addr[1:0] != 2'b00);
      default: req_bad = 1'b1;
    endcase
    // Unsigned variants exist only for loads.
    if (bus.req_we && bus.req_funct3[2]) req_bad = 1'b1;
    if (bus.req_addr[31:ADDR_W+2] != '0) req_bad = 1'b1;
  end

  // Load alignment and extension from the memory's registered read data.
  logic [31:0] ld_shift;
  logic [31:0] ld_data;

  always_comb begin
    ld_shift = mem_rdata_i >> {off_q, 3'b000};
    case (f3_q)
      3'b000:  ld_data = {{24{ld_shift[7]}}, ld_shift[7:0]};
      3'b001:  ld_data = {{16{ld_shift[15]}}, ld_shift[15:0]};
      3'b100:  ld_data = {24'h0, ld_shift[7:0]};
      3'b101:  ld_data = {16'h0, ld_shift[15:0]};
      default: ld_data = ld_shift;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    op_we_d     = op_we_q;
    f3_d        = f3_q;
    off_d       = off_q;
    mem_addr_d  = mem_addr_q;
    mem_we_d    = 4'b0000;
    mem_rd_d    = 1'b0;
    mem_wdata_d = mem_wdata_q;
    err_d       = err_q;
    rdata_d     = rdata_q;
    ld_cap_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          op_we_d = bus.req_we;
          f3_d    = bus.req_funct3;
          off_d   = bus.req_addr[1:0];
          err_d   = req_bad;
          rdata_d = '0;
          if (req_bad) begin
            state_d = RESP;
          end else begin
            state_d    = ACCESS;
            mem_addr_d = bus.req_addr[ADDR_W+1:2];
            // Enables are registered here so they are live for exactly the ACCESS cycle.
            if (bus.req_we) begin
              mem_we_d    = req_be;
              mem_wdata_d = req_wlane;
            end
          end
        end
      end
      ACCESS: begin
        if (op_we_q) begin
          state_d = RESP;
        end else begin
          state_d  = LD_WAIT;
          mem_rd_d = 1'b1;
        end
      end
      LD_WAIT: begin
        state_d  = RESP;
        ld_cap_d = 1'b1;
      end
      RESP: begin
        if (ld_cap_q) rdata_d = ld_data;
        if (bus.resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      op_we_q     <= 1'b0;
      f3_q        <= 3'b000;
      off_q       <= 2'b00;
      mem_addr_q  <= '0;
      mem_we_q    <= 4'b0000;
      mem_rd_q    <= 1'b0;
      mem_wdata_q <= '0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      ld_cap_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_we_q     <= op_we_d;
      f3_q        <= f3_d;
      off_q       <= off_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_rd_q    <= mem_rd_d;
      mem_wdata_q <= mem_wdata_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      ld_cap_q    <= ld_cap_d;
    end
  end

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.resp_valid = (state_q == RESP);
  assign bus.resp_err   = err_q;
  // First RESP cycle forwards the memory's read register directly; the
  // captured copy then holds the value while the core stalls.
  assign bus.resp_rdata = ld_cap_q ? ld_data : rdata_q;
  assign mem_addr_o     = mem_addr_q;
  assign mem_rd_o       = mem_rd_q;
  assign mem_we_o       = mem_we_q;
  assign mem_wdata_o    = mem_wdata_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
module tb_lsu_mem_ctrl;
  localparam int ADDR_W = 9;

  logic              clk;
  logic              rst_n;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [3:0]        mem_we;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  lsu_mem_ctrl_if bus();

  lsu_mem_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .mem_addr_o (mem_addr),
    .mem_rd_o   (mem_rd),
    .mem_we_o   (mem_we),
    .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory: registered address, rd-gated registered read data.
  logic [31:0]       env_mem [0:(1<<ADDR_W)-1];
  logic [ADDR_W-1:0] env_addr_q;
  logic [31:0]       env_rdata_q;

  always @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (mem_we[b]) env_mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
    env_addr_q <= mem_addr;
    if (mem_rd) env_rdata_q <= env_mem[env_addr_q];
  end
  assign mem_rdata = env_rdata_q;

  // Reference model: byte-addressed memory image of the first 128 bytes.
  logic [7:0] ref_bytes [0:127];

  int n_checks = 0;
  int n_fail   = 0;
  int n_txn    = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  function automatic bit ref_err(input logic we, input logic [2:0] f3, input logic [31:0] addr);
    int size;
    if (!(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b1;
    if (we && f3 >= 3'd4) return 1'b1;
    size = 1 << f3[1:0];
    if ((addr % size) != 0) return 1'b1;
    if (addr >= 32'd2048) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr);
    int size;
    logic [31:0] v;
    size = 1 << f3[1:0];
    v = 0;
    for (int i = 0; i < size; i++) v = v + (32'(ref_bytes[addr + i]) << (8 * i));
    if (f3 < 3'd4 && size < 4 && v[8*size-1]) v = v - (32'd1 << (8 * size));
    return v;
  endfunction

  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input int hold, output logic [31:0] got);
    bit          e_err;
    int          e_lat, size, lat, we_cnt, rd_cnt;
    logic [31:0] e_rdata, e_w, m, wdata_seen, held;
    logic [3:0]  e_be, we_seen;
    logic [ADDR_W-1:0] addr_seen;
    e_err   = ref_err(we, f3, addr);
    e_lat   = e_err ? 1 : (we ? 2 : 3);
    e_rdata = (e_err || we) ? 32'h0 : ref_load(f3, addr);
    size    = 1 << f3[1:0];
    e_be    = 4'h0;
    e_w     = 32'h0;
    if (!e_err && we)
      for (int i = 0; i < size; i++) begin
        e_be[addr[1:0] + i] = 1'b1;
        e_w[8*(addr[1:0]+i) +: 8] = wd[8*i +: 8];
      end
    m = {{8{e_be[3]}}, {8{e_be[2]}}, {8{e_be[1]}}, {8{e_be[0]}}};

    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wd;
    bus.resp_ready = 1'b0;
    @(posedge clk);
    lat = 0; we_cnt = 0; rd_cnt = 0; we_seen = 0; wdata_seen = 0; addr_seen = 0;
    for (int n = 1; n <= 8 && lat == 0; n++) begin
      @(negedge clk);
      if (n == 1) begin
        // Garbage request while busy must be ignored.
        bus.req_we     = 1'($urandom);
        bus.req_funct3 = 3'($urandom);
        bus.req_addr   = $urandom & 32'h7F;
        bus.req_wdata  = $urandom;
        bus.resp_ready = 1'($urandom);
      end
      if (mem_we != 4'h0) begin
        we_cnt++; we_seen = mem_we; wdata_seen = mem_wdata; addr_seen = mem_addr;
      end
      if (mem_rd) begin
        rd_cnt++; addr_seen = mem_addr;
      end
      if (bus.resp_valid) lat = n;
      else bus.resp_ready = 1'($urandom);
    end
    bus.resp_ready = 1'b0;
    check_eq("latency", lat, e_lat);
    check_eq("resp_err", bus.resp_err, e_err);
    check_eq("resp_rdata", bus.resp_rdata, e_rdata);
    check_eq("we_cycles", we_cnt, (we && !e_err) ? 1 : 0);
    check_eq("rd_cycles", rd_cnt, (!we && !e_err) ? 1 : 0);
    if (!e_err) check_eq("mem_addr", addr_seen, addr[ADDR_W+1:2]);
    if (!e_err && we) begin
      check_eq("mem_we", we_seen, e_be);
      check_eq("mem_wdata", wdata_seen & m, e_w);
    end
    got  = bus.resp_rdata;
    held = bus.resp_rdata;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check_eq("hold_valid", bus.resp_valid, 1'b1);
      check_eq("hold_rdata", bus.resp_rdata, held);
      check_eq("hold_ready", bus.req_ready, 1'b0);
    end
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.resp_ready = 1'b0;
    check_eq("back_idle", bus.req_ready, 1'b1);
    check_eq("valid_drop", bus.resp_valid, 1'b0);
    if (!e_err && we)
      for (int i = 0; i < size; i++) ref_bytes[addr + i] = wd[8*i +: 8];
    n_txn++;
    $display("txn %0d we=%0d f3=%0d addr=0x%08h wdata=0x%08h rdata=0x%08h err=%0d lat=%0d",
             n_txn, we, f3, addr, wd, got, e_err, lat);
  endtask

  task automatic check_reset_outputs(input string pfx);
    check_eq({pfx, "_req_ready"}, bus.req_ready, 1'b1);
    check_eq({pfx, "_resp_valid"}, bus.resp_valid, 1'b0);
    check_eq({pfx, "_resp_err"}, bus.resp_err, 1'b0);
    check_eq({pfx, "_resp_rdata"}, bus.resp_rdata, 32'h0);
    check_eq({pfx, "_mem_we"}, mem_we, 4'h0);
    check_eq({pfx, "_mem_rd"}, mem_rd, 1'b0);
    check_eq({pfx, "_mem_addr"}, mem_addr, 32'h0);
    check_eq({pfx, "_mem_wdata"}, mem_wdata, 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] got;
    logic [31:0] a, d;
    logic [2:0]  f3;
    logic        we;
    int          r, size;

    rst_n          = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;
    bus.resp_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("reset");

    // Fill the modelled region with known words.
    for (int w = 0; w < 32; w++) do_req(1'b1, 3'b010, 32'(w * 4), $urandom, 0, got);

    // Directed scenarios.
    do_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 0, got);
    do_req(1'b0, 3'b010, 32'h10, 32'h0, 5, got);
    check_eq("lw_deadbeef", got, 32'hDEADBEEF);
    do_req(1'b1, 3'b000, 32'h13, 32'h000000A5, 0, got);
    do_req(1'b0, 3'b000, 32'h13, 32'h0, 0, got);
    check_eq("lb_a5", got, 32'hFFFFFFA5);
    do_req(1'b0, 3'b100, 32'h13, 32'h0, 0, got);
    check_eq("lbu_a5", got, 32'h000000A5);
    do_req(1'b0, 3'b010, 32'h10, 32'h0, 0, got);
    check_eq("sb_others_kept", got, 32'hA5ADBEEF);
    do_req(1'b1, 3'b001, 32'h22, 32'h00008001, 0, got);
    do_req(1'b0, 3'b001, 32'h22, 32'h0, 0, got);
    check_eq("lh_8001", got, 32'hFFFF8001);
    do_req(1'b0, 3'b101, 32'h22, 32'h0, 0, got);
    check_eq("lhu_8001", got, 32'h00008001);
    do_req(1'b0, 3'b010, 32'h11, 32'h0, 0, got);
    do_req(1'b1, 3'b001, 32'h03, 32'h1234, 0, got);
    do_req(1'b0, 3'b011, 32'h00, 32'h0, 0, got);
    do_req(1'b0, 3'b010, 32'h800, 32'h0, 0, got);
    do_req(1'b1, 3'b100, 32'h04, 32'h55, 0, got);

    // Async reset during the ACCESS cycle of a store.
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_funct3 = 3'b010;
    bus.req_addr   = 32'h30;
    bus.req_wdata  = 32'hCAFEF00D;
    @(posedge clk);
    #2;
    bus.req_valid = 1'b0;
    check_eq("pre_rst_mem_we", mem_we, 4'hF);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    do_req(1'b0, 3'b010, 32'h30, 32'h0, 0, got);

    // Randomized traffic against the reference model.
    for (int t = 0; t < 150; t++) begin
      r  = $urandom_range(0, 99);
      we = 1'($urandom_range(0, 1));
      if (we) f3 = 3'($urandom_range(0, 2));
      else begin
        f3 = 3'($urandom_range(0, 3));
        if (f3 == 3'd3) f3 = 3'd4 + 3'($urandom_range(0, 1));
      end
      size = 1 << f3[1:0];
      a = 32'($urandom_range(0, 127));
      a = a & ~(32'(size) - 32'd1);
      d = $urandom;
      if (r < 8) f3 = 3'($urandom_range(0, 7));
      else if (r < 14) a = 32'($urandom_range(0, 127));
      else if (r < 18) a = a | (32'd1 << $urandom_range(11, 31));
      do_req(we, f3, a, d, $urandom_range(0, 3), got);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
